echo_cmd_seq: RTL

Synthesizable command sequencer that drives the `echo_top` init/load/fetch handshake from a stream of encoded commands. It sits between a host-side command source and the echo core. It issues strobes, waits for `ack` with per-command timeouts, checks fetched data against expected values, and reports sticky error and completion status. It replaces bench-driven sequencing for on-chip self-test and bring-up.

---
 rtl/echo_pkg.sv | 28 ++
 rtl/echo_seq_timer.sv | 38 +++
 rtl/echo_cmd_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// Shared opcodes, error codes and sequencer state encoding for the echo command sequencer.
package echo_pkg;

    localparam int ECHO_IOSIZE = 16;
    localparam int ECHO_TOW    = 16;

    localparam logic [3:0] OP_INIT    = 4'd3;
    localparam logic [3:0] OP_WAITFOR = 4'd5;
    localparam logic [3:0] OP_LOAD    = 4'd6;
    localparam logic [3:0] OP_FETCH   = 4'd7;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam logic [1:0] ERR_BAD_OP   = 2'b00;
    localparam logic [1:0] ERR_LOAD_TO  = 2'b01;
    localparam logic [1:0] ERR_FETCH_TO = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_FETCH,
        S_WAIT,
        S_HALTED,
        S_ERROR
    } seq_state_t;

endpackage

// File: rtl/echo_seq_timer.sv
// Loadable saturating cycle counter; expired flags the cycle that reaches the loaded limit.
// Latency: expired is combinational from the counter; load restarts counting next cycle.
// Backpressure: none, counts only while en is high.
module echo_seq_timer #(
    parameter int TOW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [TOW-1:0] limit,
    input  logic           en,
    output logic           expired,
    output logic           unlimited
);

    logic [TOW-1:0] cnt_q;
    logic [TOW-1:0] limit_q;
    logic [TOW:0]   cnt_inc;

    // cnt_q is the number of enabled cycles already spent, so the current
    // cycle is the limit-th one when cnt_q + 1 reaches the limit.
    assign cnt_inc   = {1'b0, cnt_q} + {{TOW{1'b0}}, 1'b1};
    assign expired   = cnt_inc >= {1'b0, limit_q};
    assign unlimited = (limit_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            limit_q <= '0;
        end else if (load) begin
            cnt_q   <= '0;
            limit_q <= limit;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_inc[TOW-1:0];
        end
    end

endmodule

// File: rtl/echo_cmd_seq.sv
// Command sequencer driving the echo core init/load/fetch handshake with timeouts and data checks.
// Latency: strobe rises the cycle after acceptance; one-cycle LOAD/FETCH allows back-to-back commands.
// Backpressure: cmd_ready is registered and high only in IDLE; HALTED/ERROR block until rst.
module echo_cmd_seq
    import echo_pkg::*;
#(
    parameter int IOSIZE = ECHO_IOSIZE,
    parameter int TOW    = ECHO_TOW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [IOSIZE-1:0] cmd_data,
    input  logic [TOW-1:0]    cmd_arg,
    input  logic              cmd_hold,
    output logic              core_init,
    output logic              core_load,
    output logic              core_fetch,
    output logic [IOSIZE-1:0] core_idata,
    input  logic              core_ack,
    input  logic [IOSIZE-1:0] core_odata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [IOSIZE-1:0] last_odata,
    output logic [31:0]       cycle_count
);

    seq_state_t        state_q, state_nxt;
    logic              cmd_ready_q;
    logic [IOSIZE-1:0] data_q, idata_q, last_odata_q;
    logic              hold_q;
    logic              hold_load_q, hold_load_nxt;
    logic              hold_fetch_q, hold_fetch_nxt;
    logic [1:0]        err_code_q, err_code_nxt;
    logic [31:0]       cycle_q;
    logic              accept, drop_load, drop_fetch;
    logic              tmr_en, tmr_expired, tmr_unlimited, timeout;

    // A held strobe survives WAITFOR/HALT acceptance; only a competing strobe opcode drops it at once.
    assign accept     = cmd_ready_q && cmd_valid;
    assign drop_load  = accept && ((cmd_op == OP_INIT) || (cmd_op == OP_FETCH));
    assign drop_fetch = accept && ((cmd_op == OP_INIT) || (cmd_op == OP_LOAD));
    assign tmr_en     = (((state_q == S_LOAD) || (state_q == S_FETCH)) && !core_ack)
                      || (state_q == S_WAIT);
    assign timeout    = tmr_expired && !tmr_unlimited;

    echo_seq_timer #(.TOW(TOW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .limit     (cmd_arg),
        .en        (tmr_en),
        .expired   (tmr_expired),
        .unlimited (tmr_unlimited)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b0;
            data_q       <= '0;
            idata_q      <= '0;
            last_odata_q <= '0;
            hold_q       <= 1'b0;
            hold_load_q  <= 1'b0;
            hold_fetch_q <= 1'b0;
            err_code_q   <= ERR_BAD_OP;
            cycle_q      <= '0;
        end else begin
            state_q      <= state_nxt;
            cmd_ready_q  <= (state_nxt == S_IDLE);
            hold_load_q  <= hold_load_nxt;
            hold_fetch_q <= hold_fetch_nxt;
            err_code_q   <= err_code_nxt;
            cycle_q      <= cycle_q + 32'd1;
            if (accept) begin
                data_q <= cmd_data;
                hold_q <= cmd_hold;
                if (cmd_op == OP_LOAD) begin
                    idata_q <= cmd_data;
                end
            end
            if ((state_q == S_FETCH) && core_ack) begin
                last_odata_q <= core_odata;
            end
        end
    end

    always_comb begin
        state_nxt      = state_q;
        err_code_nxt   = err_code_q;
        hold_load_nxt  = hold_load_q;
        hold_fetch_nxt = hold_fetch_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_INIT:    state_nxt = S_INIT;
                        OP_WAITFOR: state_nxt = S_WAIT;
                        OP_LOAD:    state_nxt = S_LOAD;
                        OP_FETCH:   state_nxt = S_FETCH;
                        OP_HALT:    state_nxt = S_HALTED;
                        default: begin
                            state_nxt    = S_ERROR;
                            err_code_nxt = ERR_BAD_OP;
                        end
                    endcase
                end
            end
            S_INIT: state_nxt = S_IDLE;
            S_LOAD: begin
                if (core_ack) begin
                    state_nxt     = S_IDLE;
                    hold_load_nxt = hold_q;
                end else if (timeout) begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = ERR_LOAD_TO;
                end
            end
            S_FETCH: begin
                if (core_ack) begin
                    hold_fetch_nxt = hold_q;
                    if (core_odata == data_q) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt    = S_ERROR;
                        err_code_nxt = ERR_MISMATCH;
                    end
                end else if (timeout) begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = ERR_FETCH_TO;
                end
            end
            S_WAIT: begin
                if (tmr_expired) begin
                    state_nxt = S_IDLE;
                end
            end
            S_HALTED, S_ERROR: state_nxt = state_q;
            default: state_nxt = S_IDLE;
        endcase
        if (drop_load) begin
            hold_load_nxt = 1'b0;
        end
        if (drop_fetch) begin
            hold_fetch_nxt = 1'b0;
        end
        if ((state_nxt == S_HALTED) || (state_nxt == S_ERROR)) begin
            hold_load_nxt  = 1'b0;
            hold_fetch_nxt = 1'b0;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign core_init   = (state_q == S_INIT);
    assign core_load   = (state_q == S_LOAD)  || (hold_load_q  && !drop_load);
    assign core_fetch  = (state_q == S_FETCH) || (hold_fetch_q && !drop_fetch);
    assign core_idata  = idata_q;
    assign busy        = !((state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_ERROR));
    assign done        = (state_q == S_HALTED);
    assign err         = (state_q == S_ERROR);
    assign err_code    = err_code_q;
    assign last_odata  = last_odata_q;
    assign cycle_count = cycle_q;

endmodule
